fft_bitrev_reorder: RTL and testbench
=====================================

Name: fft_bitrev_reorder

Overview:
- Sits directly downstream of the radix-2 DIF FFT serial output, which delivers each frame of N=2**POW complex bins in bit-reversed order.
- Buffers each frame in a ping-pong (two-bank) register store.
- Replays the frame in natural bin order (0..N-1) with a valid/ready handshake, plus frame markers and bin index.
- Input side has no backpressure; the block detects and flags frame drops.

Parameters:
- DATA_WIDTH, 17, width of each real/imag sample (matches FFT output width 11+2*3).
- POW, 3, log2 of frame length N; legal range 1..10.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample strobe, one sample per asserted cycle
- in_sop  in  1  marks the first sample of an input frame; qualified by in_valid
- in_r  in  DATA_WIDTH  real part, signed, bit-reversed order
- in_i  in  DATA_WIDTH  imaginary part, signed
- out_ready  in  1  downstream accepts the current output sample
- out_valid  out  1  output sample available
- out_r  out  DATA_WIDTH  real part, natural order
- out_i  out  DATA_WIDTH  imaginary part
- out_idx  out  POW  bin index of the current output (0..N-1)
- out_sop  out  1  out_valid and out_idx==0
- out_eop  out  1  out_valid and out_idx==N-1
- ovf  out  1  sticky: at least one input frame was dropped
- ovf_clr  in  1  synchronous clear of ovf

Behaviour:
- Storage: two banks, each holding N entries of {r,i}. Each bank has a full flag.
- Write pointers: wr_bank (1 bit), wr_cnt (POW bits).
- Read pointers: rd_bank (1 bit), rd_cnt (POW bits).
- Reset: all counters, bank pointers and full flags are 0; ovf=0; drop=0; out_valid/out_sop/out_eop=0. Bank contents are not reset.
  - out_r, out_i and out_idx are undefined while out_valid=0; the bench ignores them in that state.
- Write address: bitrev(wr_cnt), where bit k maps to bit POW-1-k.
- On in_valid with drop=0 and full[wr_bank]=0:
  - store the sample at the write address;
  - increment wr_cnt;
  - if wr_cnt==N-1: set full[wr_bank], toggle wr_bank, set wr_cnt to 0.
- Frame drop: in_valid at wr_cnt==0 with full[wr_bank]=1 sets drop=1 and ovf=1.
  - The sample is discarded; wr_cnt still advances.
  - While drop=1, samples are discarded but counted.
  - At wr_cnt==N-1, drop clears and wr_cnt wraps to 0.
  - Whole frames are dropped, never partial ones.
- in_sop handling: when in_valid and in_sop, the sample is treated as index 0.
  - wr_cnt is forced to 0 before the write and drop is re-evaluated.
  - A partially written frame is abandoned; its bank's full flag stays 0; ovf is not set.
  - in_sop at wr_cnt==0 is a no-op realign.
- Read side:
  - out_valid = full[rd_bank].
  - out_r/out_i = bank[rd_bank][rd_cnt].
  - out_idx = rd_cnt.
  - The read path is combinational from registers.
- Transfer: out_valid and out_ready.
  - Increment rd_cnt.
  - At rd_cnt==N-1: clear full[rd_bank], toggle rd_bank, set rd_cnt to 0.
- While out_valid=1 and out_ready=0, all outputs hold stable.
- Simultaneous events:
  - A write completion on one bank and a read completion on the other bank in the same cycle both take effect.
  - A write completion and a read completion can never target the same bank.
- Latency: the last input sample of a frame written at edge t gives out_valid=1 in the cycle after t, when the read bank is idle.
- Throughput: with out_ready tied high, continuous input is sustained indefinitely with no drops.
- ovf_clr clears ovf. If a new drop is detected in the same cycle, set wins.
- Reset asserted mid-frame discards everything. The first post-reset frame begins at the first in_valid (or in_sop).

Decomposition:
- Shared package fft_pkg, holding:
  - the bitrev(value, POW) function;
  - localparam N = 2**POW helper;
  - typedef of a complex sample struct {signed r, signed i} parameterised by width via the module.
- One sub-module is natural: fft_pingpong_bank.
  - Contains the two-bank register store.
  - Interfaces: write port (bank, addr, data, we) and read port (bank, addr, data).
- The top module keeps the counters, full flags, drop logic and handshake.

Test Plan:
- Natural reorder (POW=3): feed in_sop and 8 samples with in_r=bitrev(j)={0,4,2,6,1,5,3,7}, in_i=-in_r, out_ready=1.
  - Expect out_r=0..7 and out_i=0..-7.
  - out_sop with idx 0, out_eop with idx 7.
  - First out_valid one cycle after the last input.
- Streaming: 4 back-to-back frames, no gaps, out_ready=1 → 32 outputs in order, ovf=0.
- Backpressure/drop: out_ready=0, feed 3 frames.
  - Frames 1 and 2 fill both banks; frame 3 is dropped and ovf=1.
  - Release out_ready → frame1 then frame2 data out, 16 outputs total.
  - ovf_clr → ovf=0.
- Hold: toggle out_ready 1,0,0,1 mid-frame → out_r/out_idx stable during the 0 cycles, and no sample is skipped or duplicated.
- Realign: 5 samples, then in_sop plus a full frame → only the second frame is output, 8 samples, ovf=0.
- Reset: assert rst_n=0 during frame output → out_valid=0 immediately; after release, a new frame is reordered correctly.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared helpers for the FFT output reorder path: frame length and bit reversal.
// Pure functions and constants only; no state.
// Backpressure: not applicable.
package fft_pkg;

    localparam int POW_MAX = 10;

    function automatic int frame_len(input int pow);
        return 1 << pow;
    endfunction

    // Reverse the low 'pow' bits of value; bits at and above 'pow' come back as zero.
    function automatic logic [POW_MAX-1:0] bitrev(input logic [POW_MAX-1:0] value, input int pow);
        logic [POW_MAX-1:0] rev;
        rev = {<<{value}};
        return rev >> (POW_MAX - pow);
    endfunction

endpackage

// File: rtl/fft_pingpong_bank.sv
// Two-bank sample store: one synchronous write port, one combinational read port.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the caller decides when to write and which bank to read.
module fft_pingpong_bank #(
    parameter int W  = 34,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_dat,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_dat
);

    logic [W-1:0] mem [2][1<<AW];

    // Contents are deliberately left unreset; full flags in the parent gate their use.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_bank][wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_bank][rd_addr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed FFT frames into natural bin order via a ping-pong store.
// Latency: last input sample written at edge t -> out_valid in the cycle after t (read bank idle).
// Backpressure: valid/ready on output; input cannot stall, so whole frames are dropped and ovf flags it.
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 17,
    parameter int POW        = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic                         in_sop,
    input  logic signed [DATA_WIDTH-1:0] in_r,
    input  logic signed [DATA_WIDTH-1:0] in_i,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] out_r,
    output logic signed [DATA_WIDTH-1:0] out_i,
    output logic [POW-1:0]               out_idx,
    output logic                         out_sop,
    output logic                         out_eop,
    output logic                         ovf,
    input  logic                         ovf_clr
);

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] r;
        logic signed [DATA_WIDTH-1:0] i;
    } sample_t;

    localparam int              N    = frame_len(POW);
    localparam logic [POW-1:0]  LAST = POW'(N - 1);

    logic [1:0]     full, full_nxt;
    logic           wr_bank, rd_bank, drop;
    logic [POW-1:0] wr_cnt, rd_cnt, wr_eff, wr_addr;
    logic           frame_start, eff_drop, we, wr_done, rd_xfer, rd_done;
    sample_t        wr_s, rd_s;

    // in_sop realigns to index 0, which also re-runs the drop decision for this frame.
    always_comb begin
        wr_eff      = (in_valid && in_sop) ? '0 : wr_cnt;
        frame_start = in_valid && (wr_eff == '0);
        eff_drop    = (wr_eff == '0) ? full[wr_bank] : drop;
        we          = in_valid && !eff_drop;
        wr_done     = we && (wr_eff == LAST);
        rd_xfer     = out_valid && out_ready;
        rd_done     = rd_xfer && (rd_cnt == LAST);
        wr_addr     = POW'(bitrev(POW_MAX'(wr_eff), POW));
        wr_s        = '{r: in_r, i: in_i};
    end

    // Write and read completions always target different banks, so both apply.
    always_comb begin
        full_nxt = full;
        if (rd_done) full_nxt[rd_bank] = 1'b0;
        if (wr_done) full_nxt[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full    <= '0;
            wr_bank <= 1'b0;
            wr_cnt  <= '0;
            drop    <= 1'b0;
            rd_bank <= 1'b0;
            rd_cnt  <= '0;
            ovf     <= 1'b0;
        end else begin
            full <= full_nxt;
            if (in_valid) begin
                wr_cnt <= (wr_eff == LAST) ? '0 : wr_eff + 1'b1;
                drop   <= eff_drop && (wr_eff != LAST);
                if (wr_done) wr_bank <= ~wr_bank;
            end
            if (frame_start && full[wr_bank]) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
            if (rd_xfer) begin
                rd_cnt <= rd_done ? '0 : rd_cnt + 1'b1;
                if (rd_done) rd_bank <= ~rd_bank;
            end
        end
    end

    fft_pingpong_bank #(
        .W  (2 * DATA_WIDTH),
        .AW (POW)
    ) u_bank (
        .clk     (clk),
        .we      (we),
        .wr_bank (wr_bank),
        .wr_addr (wr_addr),
        .wr_dat  (wr_s),
        .rd_bank (rd_bank),
        .rd_addr (rd_cnt),
        .rd_dat  (rd_s)
    );

    assign out_valid = full[rd_bank];
    assign out_r     = rd_s.r;
    assign out_i     = rd_s.i;
    assign out_idx   = rd_cnt;
    assign out_sop   = out_valid && (rd_cnt == '0);
    assign out_eop   = out_valid && (rd_cnt == LAST);

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder at POW=3: table-driven reorder check plus
// scoreboarded sequences for streaming, drop, hold, realign and reset.
module tb_fft_bitrev_reorder;

    localparam int DW = 17;
    localparam int P  = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid, in_sop, out_ready, ovf_clr;
    logic signed [DW-1:0] in_r, in_i;
    logic                 out_valid, out_sop, out_eop, ovf;
    logic signed [DW-1:0] out_r, out_i;
    logic [P-1:0]         out_idx;

    fft_bitrev_reorder #(.DATA_WIDTH(DW), .POW(P)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
        .in_r      (in_r),
        .in_i      (in_i),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_r     (out_r),
        .out_i     (out_i),
        .out_idx   (out_idx),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [DW-1:0] in_r;
        logic signed [DW-1:0] in_i;
        logic signed [DW-1:0] exp_r;
        logic signed [DW-1:0] exp_i;
        logic [P-1:0]         exp_idx;
    } vec_t;

    typedef struct {
        logic signed [DW-1:0] r;
        logic signed [DW-1:0] i;
        logic [P-1:0]         idx;
    } exp_t;

    vec_t  vt [8];
    exp_t  exp_q [$];
    exp_t  mon_e;
    int    errors = 0;
    int    checks = 0;
    int    rx_cnt = 0;
    bit    mon_en = 1'b0;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int bitrev3(input int v);
        return {v[0], v[1], v[2]};
    endfunction

    task automatic feed_frame(input int base, input bit expect_out);
        if (expect_out) begin
            for (int k = 0; k < 8; k++) begin
                exp_q.push_back('{r: DW'(base + k), i: DW'(-(base + k)), idx: P'(k)});
            end
        end
        for (int j = 0; j < 8; j++) begin
            in_valid = 1'b1;
            in_sop   = (j == 0);
            in_r     = DW'(base + bitrev3(j));
            in_i     = DW'(-(base + bitrev3(j)));
            tick();
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    // Scoreboard: every accepted output must match the next expected natural-order bin.
    always @(negedge clk) begin
        if (rst_n && mon_en && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got idx %0d r %0d, expected no output", out_idx, out_r);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_r",   out_r,   mon_e.r);
                chk("out_i",   out_i,   mon_e.i);
                chk("out_idx", out_idx, mon_e.idx);
                chk("out_sop", out_sop, mon_e.idx == 0);
                chk("out_eop", out_eop, mon_e.idx == 7);
                rx_cnt++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{17'sd0, -17'sd0, 17'sd0, -17'sd0, 3'd0};
        vt[1] = '{17'sd4, -17'sd4, 17'sd1, -17'sd1, 3'd1};
        vt[2] = '{17'sd2, -17'sd2, 17'sd2, -17'sd2, 3'd2};
        vt[3] = '{17'sd6, -17'sd6, 17'sd3, -17'sd3, 3'd3};
        vt[4] = '{17'sd1, -17'sd1, 17'sd4, -17'sd4, 3'd4};
        vt[5] = '{17'sd5, -17'sd5, 17'sd5, -17'sd5, 3'd5};
        vt[6] = '{17'sd3, -17'sd3, 17'sd6, -17'sd6, 3'd6};
        vt[7] = '{17'sd7, -17'sd7, 17'sd7, -17'sd7, 3'd7};

        rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_r = '0; in_i = '0;
        out_ready = 1'b1; ovf_clr = 1'b0;
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_sop", out_sop, 0);
        chk("post_rst_eop", out_eop, 0);

        // Natural reorder from the table
        for (int j = 0; j < 8; j++) begin
            in_valid = 1'b1;
            in_sop   = (j == 0);
            in_r     = vt[j].in_r;
            in_i     = vt[j].in_i;
            if (j == 7) chk("latency_before_last", out_valid, 0);
            tick();
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        chk("latency_first_valid", out_valid, 1);
        for (int j = 0; j < 8; j++) begin
            chk("tbl_valid", out_valid, 1);
            chk("tbl_r",     out_r,     vt[j].exp_r);
            chk("tbl_i",     out_i,     vt[j].exp_i);
            chk("tbl_idx",   out_idx,   vt[j].exp_idx);
            chk("tbl_sop",   out_sop,   j == 0);
            chk("tbl_eop",   out_eop,   j == 7);
            tick();
        end
        chk("tbl_done_valid", out_valid, 0);

        // Streaming: four back-to-back frames
        mon_en = 1'b1;
        rx_cnt = 0;
        for (int f = 0; f < 4; f++) feed_frame(100 * (f + 1), 1'b1);
        drain("stream_drain");
        chk("stream_cnt", rx_cnt, 32);
        chk("stream_ovf", ovf, 0);

        // Backpressure: two frames fill both banks, third is dropped
        out_ready = 1'b0;
        rx_cnt = 0;
        feed_frame(1000, 1'b1);
        feed_frame(2000, 1'b1);
        feed_frame(3000, 1'b0);
        chk("drop_ovf_set", ovf, 1);
        chk("drop_valid_held", out_valid, 1);
        chk("drop_first_r", out_r, 1000);
        chk("drop_first_idx", out_idx, 0);
        out_ready = 1'b1;
        drain("drop_drain");
        chk("drop_cnt", rx_cnt, 16);
        chk("drop_ovf_sticky", ovf, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", ovf, 0);

        // Hold: stall mid-frame, outputs must stay on the pending bin
        begin
            bit pat [12] = '{1, 1, 1, 0, 0, 1, 0, 1, 1, 1, 1, 1};
            rx_cnt = 0;
            feed_frame(500, 1'b1);
            for (int c = 0; c < 12; c++) begin
                out_ready = pat[c];
                if (!pat[c]) begin
                    chk("hold_pending", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        chk("hold_valid", out_valid, 1);
                        chk("hold_idx", out_idx, exp_q[0].idx);
                        chk("hold_r", out_r, exp_q[0].r);
                    end
                end
                tick();
            end
            out_ready = 1'b1;
            drain("hold_drain");
            chk("hold_cnt", rx_cnt, 8);
        end

        // Realign: partial frame abandoned by a new in_sop
        rx_cnt = 0;
        for (int j = 0; j < 5; j++) begin
            in_valid = 1'b1;
            in_sop   = (j == 0);
            in_r     = DW'(9000 + j);
            in_i     = DW'(-(9000 + j));
            tick();
        end
        feed_frame(600, 1'b1);
        drain("realign_drain");
        chk("realign_cnt", rx_cnt, 8);
        chk("realign_ovf", ovf, 0);

        // Reset while a frame is waiting on the output
        out_ready = 1'b0;
        feed_frame(700, 1'b0);
        chk("rst_mid_valid_before", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_eop", out_eop, 0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        rx_cnt = 0;
        feed_frame(800, 1'b1);
        drain("rst_after_drain");
        chk("rst_after_cnt", rx_cnt, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
